// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-stage FSM states, EX/MEM bundle width
// and the bit offsets of each EX/MEM field.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    localparam int EXMEM_W = 107;

    // EX/MEM bundle field positions (msb/lsb)
    localparam int EXMEM_BR_ADDR_MSB = 106;
    localparam int EXMEM_BR_ADDR_LSB = 75;
    localparam int EXMEM_ALU_MSB     = 74;
    localparam int EXMEM_ALU_LSB     = 43;
    localparam int EXMEM_STORE_MSB   = 42;
    localparam int EXMEM_STORE_LSB   = 11;
    localparam int EXMEM_RD_MSB      = 10;
    localparam int EXMEM_RD_LSB      = 6;
    localparam int EXMEM_WB_MSB      = 5;
    localparam int EXMEM_WB_LSB      = 4;
    localparam int EXMEM_MEM_MSB     = 3;
    localparam int EXMEM_MEM_LSB     = 1;
    localparam int EXMEM_ZERO_BIT    = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared only by rst; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer stage (main + skid) with flush-to-bubble.
// Optional downstream-stall counter enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = EXMEM_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    skid_state_t       state_reg, state_next;
    logic [DATA_W-1:0] main_reg, main_next;
    logic [DATA_W-1:0] skid_reg, skid_next;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic              push;
    logic              pop;

    assign push      = in_valid && in_ready_reg;
    assign pop       = out_valid_reg && out_ready;
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = main_reg;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next = ST_EMPTY;
            main_next  = BUBBLE_VAL;
            skid_next  = BUBBLE_VAL;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (push) begin
                        state_next = ST_ONE;
                        main_next  = in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_next = in_data;
                    end else if (push) begin
                        state_next = ST_TWO;
                        skid_next  = in_data;
                    end else if (pop) begin
                        state_next = ST_EMPTY;
                        main_next  = BUBBLE_VAL;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_next = ST_ONE;
                        main_next  = skid_reg;
                        skid_next  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    main_next  = BUBBLE_VAL;
                    skid_next  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Handshake outputs are registered from the next state so they carry no
    // combinational path from in_valid/out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            main_reg      <= BUBBLE_VAL;
            skid_reg      <= BUBBLE_VAL;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            main_reg      <= main_next;
            skid_reg      <= skid_next;
            in_ready_reg  <= (state_next != ST_TWO);
            out_valid_reg <= (state_next != ST_EMPTY);
        end
    end

`ifdef PIPE_SKID_PERF_EN
    sat_counter #(
        .W(32)
    ) u_stall_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid_reg && !out_ready),
        .count(stall_cnt)
    );
`endif

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 107, width of the stage payload (full EX/MEM bundle).
REQ-002 SHALL have parameter BUBBLE_VAL, default all-zero, payload value driven during reset and after a flush (NOP bubble).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream stage offers in_data.
REQ-006 SHALL have port in_ready  output  1  stage can accept; driven directly from a state register.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port flush  input  1  discard all held payloads (branch or exception kill).
REQ-009 SHALL have port out_valid  output  1  out_data holds a live payload.
REQ-010 SHALL have port out_ready  input  1  downstream stage accepts out_data.
REQ-011 SHALL have port out_data  output  DATA_W  registered payload to the downstream stage.
REQ-012 SHALL have port stall_cnt  output  32  downstream-stall cycle count; present only under PIPE_SKID_PERF_EN.

Function
REQ-013 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready.
REQ-014 SHALL hold two entries, main (drives out_data) and skid, under a three-state FSM: EMPTY, ONE, TWO.
REQ-015 SHALL, in EMPTY: push -> ONE with main<=in_data; otherwise stay.
REQ-016 SHALL, in ONE: push&&pop -> ONE with main<=in_data; push only -> TWO with skid<=in_data; pop only -> EMPTY; neither -> stay.
REQ-017 SHALL, in TWO: pop -> ONE with main<=skid; otherwise stay; in_ready is low, so no push.
REQ-018 SHALL drive in_ready=1 in EMPTY/ONE, 0 in TWO; out_valid=1 in ONE/TWO, 0 in EMPTY.
REQ-019 SHALL give 1-cycle latency from push in EMPTY to out_valid, and sustain one transfer per cycle when out_ready is high.
REQ-020 SHALL keep out_data stable while out_valid && !out_ready.
REQ-021 SHALL ignore in_data and in_valid whenever in_ready is low.
REQ-022 SHALL, on flush, go to EMPTY next edge, discard main and skid, set out_data to BUBBLE_VAL, and drop any same-cycle push; flush overrides all other transitions.
REQ-023 SHALL preserve payload order; no entry is duplicated or lost except by flush.
REQ-024 SHALL drive out_data to BUBBLE_VAL in EMPTY after a pop that empties the stage.

Reset
REQ-025 SHALL, on rst high, immediately force the FSM to EMPTY, out_valid=0, in_ready=1, out_data=BUBBLE_VAL, skid=BUBBLE_VAL, and stall_cnt=0.
REQ-026 SHALL discard any in-flight payload when rst asserts mid-transfer; first push after deassertion behaves as from EMPTY.

Configuration
REQ-027 SHALL, with PIPE_SKID_PERF_EN defined, increment stall_cnt each cycle out_valid && !out_ready, saturate at 32'hFFFF_FFFF, and clear it only on rst (not on flush).
REQ-028 SHALL, without PIPE_SKID_PERF_EN, omit the stall_cnt port and counter logic entirely; all other behaviour is unchanged.

Structure
REQ-029 SHALL take the FSM state enum, the DATA_W default, and EX/MEM field offsets (branch address 106:75, ALU 74:43, store data 42:11, rd 10:6, wb 5:4, mem 3:1, zero 0) from shared package pipe_pkg.
REQ-030 SHALL place the saturating counter in sub-module sat_counter, instantiated only under PIPE_SKID_PERF_EN.

Verification
REQ-031 SHALL cover: reset, then push 0x1 with out_ready=1 -> out_valid next cycle, out_data=0x1, in_ready stays 1.
REQ-032 SHALL cover: out_ready=0, push 0xA then 0xB -> state TWO, in_ready=0; raise out_ready -> 0xA then 0xB delivered in order.
REQ-033 SHALL cover: 100-payload stream, out_ready=1 -> one output per cycle, no gaps after first, sequence identical.
REQ-034 SHALL cover: state TWO, flush with push of 0xC -> next cycle EMPTY, out_valid=0, out_data=BUBBLE_VAL, 0xC never appears.
REQ-035 SHALL cover: rst asserted mid-cycle in ONE -> out_valid=0 and in_ready=1 before the next clock edge.
REQ-036 SHALL cover (PIPE_SKID_PERF_EN): hold out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5; flush -> stall_cnt stays 5.
